// File: rtl/rom_arb.sv
// Round-robin arbiter sharing one byte-wide memory port between PRG and CHR ROM readers.
// One access in flight at a time; a stalled memory is cut off after TIMEOUT cycles and answered with 8'hFF.
module rom_arb #(
   parameter logic [21:0] CHRBASE = 22'h200000,
   parameter int          TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [20:0] promaddr,
   input  logic        promreq,
   output logic        promack,
   output logic [7:0]  promdata,
   input  logic [20:0] cromaddr,
   input  logic        cromreq,
   output logic        cromack,
   output logic [7:0]  cromdata,
   output logic [21:0] maddr,
   output logic        mreq,
   input  logic        mack,
   input  logic [7:0]  mrdata,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_PRG, S_CHR, S_DONE} state_t;

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [21:0] maddr_q, maddr_d;
   logic        mreq_q, mreq_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        last_chr_q, last_chr_d;
   logic        promack_q, promack_d;
   logic        cromack_q, cromack_d;
   logic [7:0]  promdata_q, promdata_d;
   logic [7:0]  cromdata_q, cromdata_d;
   logic        err_q, err_d;
   logic        grant_prg, grant_chr;
   logic        finish;
   logic [7:0]  rdata;

   // On a tie the source that did not win last time gets the port.
   assign grant_prg = promreq && (!cromreq || last_chr_q);
   assign grant_chr = cromreq && (!promreq || !last_chr_q);

   assign finish = mack || (cnt_q == TO_LIMIT);
   assign rdata  = mack ? mrdata : 8'hFF;

   always_comb begin
      state_d    = state_q;
      maddr_d    = maddr_q;
      mreq_d     = mreq_q;
      cnt_d      = cnt_q;
      last_chr_d = last_chr_q;
      promack_d  = 1'b0;
      cromack_d  = 1'b0;
      promdata_d = promdata_q;
      cromdata_d = cromdata_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE: begin
            if (grant_prg) begin
               state_d    = S_PRG;
               maddr_d    = {1'b0, promaddr};
               mreq_d     = 1'b1;
               cnt_d      = 8'd0;
               last_chr_d = 1'b0;
            end else if (grant_chr) begin
               state_d    = S_CHR;
               maddr_d    = CHRBASE + {1'b0, cromaddr};
               mreq_d     = 1'b1;
               cnt_d      = 8'd0;
               last_chr_d = 1'b1;
            end
         end
         S_PRG, S_CHR: begin
            if (finish) begin
               state_d = S_DONE;
               mreq_d  = 1'b0;
               // A mack landing on the timeout cycle still counts as a real reply.
               if (!mack) err_d = 1'b1;
               if (state_q == S_PRG) begin
                  promack_d  = 1'b1;
                  promdata_d = rdata;
               end else begin
                  cromack_d  = 1'b1;
                  cromdata_d = rdata;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         maddr_q    <= 22'd0;
         mreq_q     <= 1'b0;
         cnt_q      <= 8'd0;
         last_chr_q <= 1'b1;
         promack_q  <= 1'b0;
         cromack_q  <= 1'b0;
         promdata_q <= 8'd0;
         cromdata_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         maddr_q    <= maddr_d;
         mreq_q     <= mreq_d;
         cnt_q      <= cnt_d;
         last_chr_q <= last_chr_d;
         promack_q  <= promack_d;
         cromack_q  <= cromack_d;
         promdata_q <= promdata_d;
         cromdata_q <= cromdata_d;
         err_q      <= err_d;
      end
   end

   assign maddr    = maddr_q;
   assign mreq     = mreq_q;
   assign promack  = promack_q;
   assign cromack  = cromack_q;
   assign promdata = promdata_q;
   assign cromdata = cromdata_q;
   assign err      = err_q;

endmodule

// File: tb/tb_rom_arb.sv
// Bench for rom_arb: directed scenarios plus randomized accesses against a transaction-level model.
module tb_rom_arb;

   localparam logic [21:0] CHRBASE = 22'h200000;
   localparam int          TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic [20:0] promaddr, cromaddr;
   logic        promreq, cromreq;
   logic        promack, cromack;
   logic [7:0]  promdata, cromdata;
   logic [21:0] maddr;
   logic        mreq;
   logic        mack;
   logic [7:0]  mrdata;
   logic        err;

   int nvec = 0;
   int nerr = 0;

   // Model state: who won last, sticky error, last data returned to each side.
   bit         m_last_chr;
   bit         m_err;
   logic [7:0] m_pd, m_cd;

   rom_arb #(.CHRBASE(CHRBASE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn),
      .promaddr(promaddr), .promreq(promreq), .promack(promack), .promdata(promdata),
      .cromaddr(cromaddr), .cromreq(cromreq), .cromack(cromack), .cromdata(cromdata),
      .maddr(maddr), .mreq(mreq), .mack(mack), .mrdata(mrdata), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " mreq"},     32'(mreq), 32'd0);
      chk({tag, " maddr"},    32'(maddr), 32'd0);
      chk({tag, " promack"},  32'(promack), 32'd0);
      chk({tag, " cromack"},  32'(cromack), 32'd0);
      chk({tag, " promdata"}, 32'(promdata), 32'd0);
      chk({tag, " cromdata"}, 32'(cromdata), 32'd0);
      chk({tag, " err"},      32'(err), 32'd0);
   endtask

   // One complete access starting from an idle arbiter; memory answers after `delay` cycles
   // of mreq (never, if delay exceeds TIMEOUT).
   task automatic do_access(input bit pr, input bit cr, input logic [20:0] pa, input logic [20:0] ca,
                            input int delay, input logic [7:0] dat, input bit drop, input string tag);
      bit          win_chr, to;
      logic [21:0] ea;
      logic [7:0]  ed;
      int          highs;
      win_chr = (pr && cr) ? !m_last_chr : cr;
      ea      = win_chr ? 22'(CHRBASE + {1'b0, ca}) : {1'b0, pa};
      to      = delay > TIMEOUT;
      ed      = to ? 8'hFF : dat;
      promaddr = pa; cromaddr = ca; promreq = pr; cromreq = cr;
      @(posedge clk); #1;
      chk({tag, " grant maddr"}, 32'(maddr), 32'(ea));
      highs = mreq ? 1 : 0;
      promaddr = 21'($urandom);
      cromaddr = 21'($urandom);
      if (drop) begin promreq = 1'b0; cromreq = 1'b0; end
      for (int k = 0; k <= TIMEOUT; k++) begin
         mrdata = 8'($urandom);
         if (k == delay) begin mack = 1'b1; mrdata = dat; end
         @(posedge clk); #1;
         mack = 1'b0;
         if (k == delay || k == TIMEOUT) break;
         if (mreq) highs++;
         chk({tag, " maddr held"}, 32'(maddr), 32'(ea));
      end
      chk({tag, " mreq cycles"}, 32'(highs), 32'((to ? TIMEOUT : delay) + 1));
      chk({tag, " promack"}, 32'(promack), 32'(!win_chr));
      chk({tag, " cromack"}, 32'(cromack), 32'(win_chr));
      chk({tag, " data"}, 32'(win_chr ? cromdata : promdata), 32'(ed));
      chk({tag, " mreq dropped"}, 32'(mreq), 32'd0);
      m_err = m_err | to;
      chk({tag, " err"}, 32'(err), 32'(m_err));
      m_last_chr = win_chr;
      if (win_chr) m_cd = ed; else m_pd = ed;
      promreq = 1'b0; cromreq = 1'b0;
      @(posedge clk); #1;
      chk({tag, " ack low"}, 32'({promack, cromack}), 32'd0);
      chk({tag, " data hold"}, 32'({promdata, cromdata}), 32'({m_pd, m_cd}));
   endtask

   initial begin
      int nack;
      logic [7:0] last_dat;
      rstn = 1'b0; promreq = 1'b0; cromreq = 1'b0; mack = 1'b0;
      promaddr = '0; cromaddr = '0; mrdata = '0;
      m_last_chr = 1'b1; m_err = 1'b0; m_pd = 8'h00; m_cd = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values("reset");

      // Both requests held from reset: strict alternation starting with PRG.
      promaddr = 21'h00042; cromaddr = 21'h00077;
      promreq = 1'b1; cromreq = 1'b1; rstn = 1'b1;
      nack = 0; last_dat = 8'h00;
      for (int c = 0; c < 20 && nack < 4; c++) begin
         @(posedge clk); #1;
         chk("rr single ack", 32'(promack & cromack), 32'd0);
         if (promack || cromack) begin
            chk("rr order", 32'(cromack), 32'(nack % 2));
            chk("rr data", 32'(cromack ? cromdata : promdata), 32'(last_dat));
            if (cromack) m_cd = last_dat; else m_pd = last_dat;
            nack++;
            if (nack == 4) begin promreq = 1'b0; cromreq = 1'b0; end
         end
         mack = mreq;
         if (mreq) begin mrdata = 8'($urandom); last_dat = mrdata; end
      end
      chk("rr ack count", 32'(nack), 32'd4);
      mack = 1'b0;
      m_last_chr = 1'b1;
      @(posedge clk); #1;

      do_access(1'b1, 1'b0, 21'h00123, 21'h0, 1, 8'hA5, 1'b0, "single prg");
      do_access(1'b0, 1'b1, 21'h0, 21'h01FFF, 0, 8'h3C, 1'b0, "single chr");
      do_access(1'b1, 1'b0, 21'h1ABCD, 21'h0, TIMEOUT, 8'h77, 1'b0, "mack at timeout");
      chk("err still clear", 32'(err), 32'd0);
      do_access(1'b1, 1'b0, 21'h00055, 21'h0, TIMEOUT + 5, 8'h00, 1'b0, "timeout");
      chk("err sticky", 32'(err), 32'd1);

      for (int i = 0; i < 40; i++) begin
         bit pr, cr;
         pr = 1'($urandom);
         cr = 1'($urandom);
         if (!pr && !cr) pr = 1'b1;
         do_access(pr, cr, 21'($urandom), 21'($urandom), int'($urandom_range(0, TIMEOUT + 2)),
                   8'($urandom), 1'($urandom), "random");
      end
      chk("err after random", 32'(err), 32'd1);

      // Reset in the middle of an access, then a stray mack.
      promaddr = 21'h0F0F0; promreq = 1'b1;
      @(posedge clk); #1;
      chk("pre-reset mreq", 32'(mreq), 32'd1);
      rstn = 1'b0;
      #1;
      chk_reset_values("mid reset");
      promreq = 1'b0;
      #1 rstn = 1'b1;
      m_last_chr = 1'b1; m_err = 1'b0; m_pd = 8'h00; m_cd = 8'h00;
      mack = 1'b1; mrdata = 8'h99;
      @(posedge clk); #1;
      mack = 1'b0;
      chk_reset_values("stray mack");
      @(posedge clk); #1;
      do_access(1'b1, 1'b1, 21'h00321, 21'h00654, 2, 8'h5A, 1'b0, "post-reset tie");
      do_access(1'b1, 1'b1, 21'h00321, 21'h00654, 0, 8'hC3, 1'b0, "post-reset tie 2");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
